// File: rtl/pipe_reg_pkg.sv
// Shared types for the inter-stage pipeline register: per-cycle operation encoding,
// statistics width, and small helpers used by the stage register.
package pipe_reg_pkg;

    typedef enum logic [2:0] {
        OP_LOAD,
        OP_HOLD,
        OP_BUBBLE,
        OP_FLUSH,
        OP_SQUASH
    } pipe_op_e;

    localparam int unsigned STAT_W = 32;

    // Reset is handled separately by the state registers; this resolves the rest of the
    // per-cycle priority. A live flush window overrides stall.
    function automatic pipe_op_e decode_op(input logic flush, input logic squash,
                                           input logic stall, input logic bubble);
        pipe_op_e op;
        if (flush) begin
            op = OP_FLUSH;
        end else if (squash) begin
            op = OP_SQUASH;
        end else if (stall) begin
            op = OP_HOLD;
        end else if (bubble) begin
            op = OP_BUBBLE;
        end else begin
            op = OP_LOAD;
        end
        return op;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (&v) ? v : v + STAT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_flush_ctr.sv
// Flush-window counter: a flush request squashes FLUSH_CYCLES consecutive cycles; a new
// request while the window is open restarts it rather than extending it.
module pipe_flush_ctr #(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    output logic squash,
    output logic flush_busy
);

    localparam int unsigned CntW = $clog2(FLUSH_CYCLES) + 1;
    localparam logic [CntW-1:0] Reload = CntW'(FLUSH_CYCLES - 1);

    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = Reload;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    // flush_busy tracks the counter register so it is high after every edge that
    // leaves squash cycles still to come.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q      <= '0;
            flush_busy <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            flush_busy <= (cnt_d != '0);
        end
    end

    assign squash = (cnt_q != '0);

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with load/hold/bubble/flush and a programmable flush window.
// Optional per-operation statistics counters are enabled by PIPE_STAGE_REG_STATS_EN.
module pipe_stage_reg
    import pipe_reg_pkg::*;
#(
    parameter int unsigned CTRL_W       = 16,
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              bubble,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [DATA_W-1:0] data_out,
`ifdef PIPE_STAGE_REG_STATS_EN
    output logic [STAT_W-1:0] stall_cnt,
    output logic [STAT_W-1:0] bubble_cnt,
    output logic [STAT_W-1:0] flush_cnt,
`endif
    output logic              flush_busy
);

    logic     squash;
    pipe_op_e op;

    pipe_flush_ctr #(
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) u_flush_ctr (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .squash     (squash),
        .flush_busy (flush_busy)
    );

    always_comb begin
        op = decode_op(flush, squash, stall, bubble);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out <= 1'b0;
            ctrl_out  <= '0;
            data_out  <= '0;
        end else begin
            unique case (op)
                OP_FLUSH, OP_SQUASH: begin
                    valid_out <= 1'b0;
                    ctrl_out  <= '0;
                    data_out  <= '0;
                end
                OP_HOLD: begin
                end
                // A bubble kills the instruction but keeps data so forwarding paths stay stable.
                OP_BUBBLE: begin
                    valid_out <= 1'b0;
                    ctrl_out  <= '0;
                end
                OP_LOAD: begin
                    valid_out <= valid_in;
                    ctrl_out  <= ctrl_in;
                    data_out  <= data_in;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_REG_STATS_EN
    // A whole flush window counts once, at the accepted request (OP_FLUSH, not OP_SQUASH).
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else begin
            if (op == OP_HOLD) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
            if (op == OP_BUBBLE) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
            if (op == OP_FLUSH) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
        end
    end
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the CPU datapath, sitting between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries a control field, a data field and a valid bit, and supports four per-cycle operations: load, hold (stall), bubble insertion and flush. The flush window length is configurable, so a single flush request can squash a programmable number of consecutive cycles.

## Interface
- CTRL_W, 16: control field width; bits cleared on bubble/flush
- DATA_W, 128: data field width (pc, operands, imm, addresses); kept on bubble, cleared on flush
- FLUSH_CYCLES, 2: number of cycles a flush request squashes; legal range 1..15
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold every output at its current value
- bubble  in  1  insert NOP: clear ctrl_out and valid_out, keep data_out
- flush  in  1  start a flush window of FLUSH_CYCLES cycles
- valid_in  in  1  upstream stage holds a real instruction
- ctrl_in  in  CTRL_W  control field from upstream
- data_in  in  DATA_W  data field from upstream
- valid_out  out  1  registered valid
- ctrl_out  out  CTRL_W  registered control
- data_out  out  DATA_W  registered data
- flush_busy  out  1  high while flush window cycles remain after the current one

## Operation
- Priority, evaluated every cycle: rst > flush > active flush window > stall > bubble > load.
- rst: valid_out=0, ctrl_out=0, data_out=0, flush counter=0, flush_busy=0.
- flush: valid_out, ctrl_out and data_out all cleared; counter loads FLUSH_CYCLES-1.
- Active flush window (counter>0, no new flush): outputs cleared; counter decrements by 1.
- A flush asserted while the window is active restarts the window: counter reloads FLUSH_CYCLES-1, never accumulates.
- stall: all outputs and the counter unchanged. Stall is ignored while a flush or flush window is active.
- bubble: valid_out=0, ctrl_out=0, data_out unchanged.
- load: valid_out<=valid_in, ctrl_out<=ctrl_in, data_out<=data_in.
- stall and bubble together: stall wins, so outputs hold.
- Counter width is $clog2(FLUSH_CYCLES)+1 bits. It never underflows and saturates at 0.
- flush_busy is the registered value of (counter != 0).
- FLUSH_CYCLES=1: flush clears for exactly one cycle and flush_busy never rises.

## Timing
- Latency: 1 cycle from any input to the outputs; no combinational path from input to output.
- A flush sampled at edge N clears the outputs after edge N. The outputs stay cleared through edge N+FLUSH_CYCLES-1. The first load can occur at edge N+FLUSH_CYCLES.
- flush_busy is high after edges N..N+FLUSH_CYCLES-2.
- Reset asserted mid-window aborts the window in the same cycle.

## Configuration
- PIPE_STAGE_REG_STATS_EN defined: adds three outputs, stall_cnt, bubble_cnt and flush_cnt, each 32 bits. Each counter increments once per cycle in which its operation is the winning operation. A flush window counts as one flush, counted at the cycle the request is accepted. Counters saturate at 32'hFFFF_FFFF and reset to 0 on rst.
- Macro undefined: these ports and counters do not exist, and the remaining behaviour is identical.

## Structure
- Package pipe_reg_pkg holds:
  - enum pipe_op_e {OP_LOAD, OP_HOLD, OP_BUBBLE, OP_FLUSH, OP_SQUASH}
  - localparam STAT_W=32
- Sub-module pipe_flush_ctr contains:
  - the flush-window counter and flush_busy
  - inputs clk, rst, flush
  - outputs squash (counter!=0) and flush_busy
- The top level decodes the priority into pipe_op_e and drives a single always_ff for the payload.

## Test plan
- Load: valid_in=1, ctrl_in=16'hA5A5, data_in=128'h1234 -> next cycle valid_out=1, ctrl_out=16'hA5A5, data_out=128'h1234.
- Bubble with data_out=128'h1234 and ctrl_in=16'hFFFF -> ctrl_out=0, valid_out=0, data_out stays 128'h1234.
- Flush with FLUSH_CYCLES=2 at edge N and load stimulus held:
  - outputs are 0 after edges N and N+1
  - flush_busy=1 only after edge N
  - loaded values appear after edge N+2
- Re-flush: flush at edge N, then again at edge N+1 (FLUSH_CYCLES=3) -> outputs remain 0 through edge N+3, and load resumes at edge N+4.
- Stall and bubble held for 3 cycles -> outputs unchanged. Stall and flush together -> outputs cleared.
- Reset asserted mid-window -> all outputs and flush_busy are 0 next cycle. With the macro defined, after 5 stalls and 2 flushes: stall_cnt=5, flush_cnt=2.
